battle_board_n: RTL and testbench

BATTLE_BOARD_N -- requirements
Module: battle_board_n

---
 rtl/battle_board_n.sv | 149 ++++++++++++++
 tb/tb_battle_board_n.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/battle_board_n.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | battle_board_n : multi-player battleship board, turn and shot resolver  |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module battle_board_n #(
    parameter int ROWS    = 4,
    parameter int COLS    = 7,
    parameter int PLAYERS = 2,
    localparam int CELLS  = ROWS * COLS,
    localparam int PW     = (PLAYERS > 2) ? $clog2(PLAYERS) : 1,
    localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CLW    = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             load_en,
    input  logic [PW-1:0]    load_player,
    input  logic [CELLS-1:0] load_ships,
    input  logic             start,
    input  logic             fire_valid,
    output logic             fire_ready,
    input  logic [RW-1:0]    fire_row,
    input  logic [CLW-1:0]   fire_col,
    output logic             resp_valid,
    output logic             resp_hit,
    output logic             resp_repeat,
    output logic             resp_error,
    output logic [PW-1:0]    turn,
    input  logic [PW-1:0]    view_player,
    output logic [CELLS-1:0] view_guess,
    output logic [1:0]       phase,
    output logic             finish,
    output logic [PW-1:0]    winner
);

    localparam int CW = $clog2(CELLS + 1);
    localparam int IW = (CELLS > 1) ? $clog2(CELLS) : 1;

    localparam logic [1:0] S_SETUP   = 2'b00;
    localparam logic [1:0] S_PLAY    = 2'b01;
    localparam logic [1:0] S_RESOLVE = 2'b10;
    localparam logic [1:0] S_DONE    = 2'b11;

    logic [1:0]       state;
    logic [CELLS-1:0] fleet [PLAYERS];
    logic [CELLS-1:0] guess [PLAYERS];
    logic [CW-1:0]    count [PLAYERS];
    logic [CW-1:0]    hits  [PLAYERS];
    logic [RW-1:0]    row_q;
    logic [CLW-1:0]   col_q;

    logic [PW-1:0]    target;
    logic [IW-1:0]    idx;
    logic             coord_err;
    logic             all_loaded;
    logic [CW-1:0]    hits_next;

    function automatic logic [CW-1:0] popcnt(input logic [CELLS-1:0] v);
        popcnt = '0;
        for (int i = 0; i < CELLS; i++) begin
            popcnt = popcnt + CW'(v[i]);
        end
    endfunction

    assign target     = (turn == PW'(PLAYERS - 1)) ? '0 : turn + 1'b1;
    assign coord_err  = (int'(row_q) >= ROWS) || (int'(col_q) >= COLS);
    assign idx        = IW'(int'(row_q) * COLS + int'(col_q));
    assign hits_next  = hits[turn] + CW'(1);
    assign fire_ready = (state == S_PLAY);
    assign phase      = state;
    assign finish     = (state == S_DONE);
    assign view_guess = (int'(view_player) < PLAYERS) ? guess[view_player] : '0;

    always_comb begin
        all_loaded = 1'b1;
        for (int p = 0; p < PLAYERS; p++) begin
            if (count[p] == '0) all_loaded = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state       <= S_SETUP;
            turn        <= '0;
            winner      <= '0;
            resp_valid  <= 1'b0;
            resp_hit    <= 1'b0;
            resp_repeat <= 1'b0;
            resp_error  <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            for (int p = 0; p < PLAYERS; p++) begin
                fleet[p] <= '0;
                guess[p] <= '0;
                count[p] <= '0;
                hits[p]  <= '0;
            end
        end else begin
            resp_valid  <= 1'b0;
            resp_hit    <= 1'b0;
            resp_repeat <= 1'b0;
            resp_error  <= 1'b0;
            case (state)
                S_SETUP: begin
                    // start sees the counts as they were before any same-cycle load
                    if (load_en && (int'(load_player) < PLAYERS)) begin
                        fleet[load_player] <= load_ships;
                        count[load_player] <= popcnt(load_ships);
                    end
                    if (start && all_loaded) state <= S_PLAY;
                end
                S_PLAY: begin
                    if (fire_valid) begin
                        row_q <= fire_row;
                        col_q <= fire_col;
                        state <= S_RESOLVE;
                    end
                end
                S_RESOLVE: begin
                    resp_valid <= 1'b1;
                    state      <= S_PLAY;
                    if (coord_err) begin
                        resp_error <= 1'b1;
                    end else if (guess[turn][idx]) begin
                        resp_repeat <= 1'b1;
                    end else begin
                        guess[turn][idx] <= 1'b1;
                        if (fleet[target][idx]) begin
                            resp_hit   <= 1'b1;
                            hits[turn] <= hits_next;
                            if (hits_next == count[target]) begin
                                state  <= S_DONE;
                                winner <= turn;
                            end else begin
                                turn <= target;
                            end
                        end else begin
                            turn <= target;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_battle_board_n.sv
`default_nettype none
`timescale 1ns/1ps
// Scoreboard bench for battle_board_n: 2-player game, reset-abort and a 3-player rotation.
module tb_battle_board_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int pass_cnt = 0;
    int total    = 0;

    // two-player instance
    logic        clr_n, load_en, load_player, start, fire_valid, view_player;
    logic [27:0] load_ships;
    logic [1:0]  fire_row;
    logic [2:0]  fire_col;
    logic        fire_ready, resp_valid, resp_hit, resp_repeat, resp_error, finish;
    logic        turn, winner;
    logic [27:0] view_guess;
    logic [1:0]  phase;

    battle_board_n dut (
        .clk(clk), .clr_n(clr_n), .load_en(load_en), .load_player(load_player),
        .load_ships(load_ships), .start(start), .fire_valid(fire_valid),
        .fire_ready(fire_ready), .fire_row(fire_row), .fire_col(fire_col),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_repeat(resp_repeat),
        .resp_error(resp_error), .turn(turn), .view_player(view_player),
        .view_guess(view_guess), .phase(phase), .finish(finish), .winner(winner)
    );

    // three-player instance
    logic        b_clr_n, b_load_en, b_start, b_fire_valid;
    logic [1:0]  b_load_player, b_view_player, b_turn, b_winner, b_phase;
    logic [27:0] b_load_ships, b_view_guess;
    logic [1:0]  b_fire_row;
    logic [2:0]  b_fire_col;
    logic        b_fire_ready, b_resp_valid, b_resp_hit, b_resp_repeat, b_resp_error, b_finish;

    battle_board_n #(.PLAYERS(3)) dut_b (
        .clk(clk), .clr_n(b_clr_n), .load_en(b_load_en), .load_player(b_load_player),
        .load_ships(b_load_ships), .start(b_start), .fire_valid(b_fire_valid),
        .fire_ready(b_fire_ready), .fire_row(b_fire_row), .fire_col(b_fire_col),
        .resp_valid(b_resp_valid), .resp_hit(b_resp_hit), .resp_repeat(b_resp_repeat),
        .resp_error(b_resp_error), .turn(b_turn), .view_player(b_view_player),
        .view_guess(b_view_guess), .phase(b_phase), .finish(b_finish), .winner(b_winner)
    );

    typedef struct {
        logic hit;
        logic rep;
        logic err;
        int   cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // monitor: every response pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (resp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                e_mon = sb.pop_front();
                check("resp_hit", 32'(resp_hit), 32'(e_mon.hit));
                check("resp_repeat", 32'(resp_repeat), 32'(e_mon.rep));
                check("resp_error", 32'(resp_error), 32'(e_mon.err));
                check("resp_latency", 32'(cyc), 32'(e_mon.cyc));
            end
        end
    end

    task automatic load(input logic p, input logic [27:0] ships);
        @(negedge clk);
        load_en = 1'b1; load_player = p; load_ships = ships;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic fire(input int r, input int c, input logic eh, input logic er,
                        input logic ee, input int exp_turn);
        int n = 0;
        @(negedge clk);
        while (!fire_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("fire_ready_wait", 32'(fire_ready), 32'd1);
        fire_valid = 1'b1; fire_row = r[1:0]; fire_col = c[2:0];
        @(posedge clk); #1;
        sb.push_back('{hit: eh, rep: er, err: ee, cyc: cyc + 1});
        fire_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("turn_after_shot", 32'(turn), 32'(exp_turn));
    endtask

    task automatic fire_b(input int r, input int c, input logic eh, input int exp_turn);
        int n = 0;
        @(negedge clk);
        while (!b_fire_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b_fire_ready_wait", 32'(b_fire_ready), 32'd1);
        b_fire_valid = 1'b1; b_fire_row = r[1:0]; b_fire_col = c[2:0];
        @(posedge clk); #1;
        b_fire_valid = 1'b0;
        @(negedge clk);
        check("b_resp_early", 32'(b_resp_valid), 32'd0);
        @(negedge clk);
        check("b_resp_valid", 32'(b_resp_valid), 32'd1);
        check("b_resp_hit", 32'(b_resp_hit), 32'(eh));
        check("b_turn", 32'(b_turn), 32'(exp_turn));
    endtask

    task automatic load_b(input logic [1:0] p, input logic [27:0] ships);
        @(negedge clk);
        b_load_en = 1'b1; b_load_player = p; b_load_ships = ships;
        @(negedge clk);
        b_load_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clr_n = 1'b0; load_en = 1'b0; load_player = 1'b0; load_ships = '0; start = 1'b0;
        fire_valid = 1'b0; fire_row = '0; fire_col = '0; view_player = 1'b0;
        b_clr_n = 1'b0; b_load_en = 1'b0; b_load_player = '0; b_load_ships = '0; b_start = 1'b0;
        b_fire_valid = 1'b0; b_fire_row = '0; b_fire_col = '0; b_view_player = 2'd2;
        #2;
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_turn", 32'(turn), 32'd0);
        check("rst_finish", 32'(finish), 32'd0);
        check("rst_winner", 32'(winner), 32'd0);
        check("rst_fire_ready", 32'(fire_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_flags", {29'd0, resp_hit, resp_repeat, resp_error}, 32'd0);
        check("rst_view_guess", 32'(view_guess), 32'd0);
        #10;
        clr_n = 1'b1; b_clr_n = 1'b1;

        // setup: P1 empty blocks start; start alongside P1 load uses pre-load count
        load(1'b0, 28'h0000001);
        pulse_start();
        check("start_p1_empty", 32'(phase), 32'd0);
        @(negedge clk);
        load_en = 1'b1; load_player = 1'b1; load_ships = 28'h8000020; start = 1'b1;
        @(negedge clk);
        load_en = 1'b0; start = 1'b0;
        check("start_same_cycle_load", 32'(phase), 32'd0);
        pulse_start();
        check("phase_play", 32'(phase), 32'd1);
        check("fire_ready_play", 32'(fire_ready), 32'd1);

        fire(0, 5, 1'b1, 1'b0, 1'b0, 1);   // P0 hits P1 cell 5
        fire(3, 6, 1'b0, 1'b0, 1'b0, 0);   // P1 misses P0 cell 27
        fire(0, 1, 1'b0, 1'b0, 1'b0, 1);   // P0 misses cell 1
        fire(3, 6, 1'b0, 1'b1, 1'b0, 1);   // P1 repeats cell 27
        fire(0, 7, 1'b0, 1'b0, 1'b1, 1);   // column out of range
        view_player = 1'b0; #1;
        check("guess_p0", 32'(view_guess), 32'h0000022);
        view_player = 1'b1; #1;
        check("guess_p1", 32'(view_guess), 32'h8000000);
        fire(0, 2, 1'b0, 1'b0, 1'b0, 0);   // P1 misses cell 2
        fire(3, 6, 1'b1, 1'b0, 1'b0, 0);   // P0 sinks P1 -> win
        check("done_phase", 32'(phase), 32'd3);
        check("done_finish", 32'(finish), 32'd1);
        check("done_winner", 32'(winner), 32'd0);
        check("done_fire_ready", 32'(fire_ready), 32'd0);

        // DONE ignores everything
        @(negedge clk);
        fire_valid = 1'b1; load_en = 1'b1; start = 1'b1; load_ships = '0;
        repeat (4) @(negedge clk);
        fire_valid = 1'b0; load_en = 1'b0; start = 1'b0;
        check("done_held_phase", 32'(phase), 32'd3);
        check("done_held_ready", 32'(fire_ready), 32'd0);

        // reset during RESOLVE aborts the shot
        @(negedge clk); clr_n = 1'b0;
        @(negedge clk); clr_n = 1'b1;
        load(1'b0, 28'h0000001);
        load(1'b1, 28'h8000020);
        pulse_start();
        @(negedge clk);
        fire_valid = 1'b1; fire_row = 2'd0; fire_col = 3'd5;
        @(posedge clk); #1;
        fire_valid = 1'b0;
        check("resolve_phase", 32'(phase), 32'd2);
        #2 clr_n = 1'b0;
        #1;
        check("abort_phase", 32'(phase), 32'd0);
        check("abort_turn", 32'(turn), 32'd0);
        check("abort_ready", 32'(fire_ready), 32'd0);
        check("abort_finish", 32'(finish), 32'd0);
        view_player = 1'b0; #1;
        check("abort_guess", 32'(view_guess), 32'd0);
        #3 clr_n = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_no_resp", 32'(resp_valid), 32'd0);
        check("abort_still_setup", 32'(phase), 32'd0);

        // three players: misses rotate 0->1->2, P2 targets P0 and wraps to 0
        load_b(2'd0, 28'h0000003);
        load_b(2'd1, 28'h0000004);
        load_b(2'd2, 28'h0000008);
        @(negedge clk); b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        check("b_phase_play", 32'(b_phase), 32'd1);
        check("b_turn0", 32'(b_turn), 32'd0);
        fire_b(1, 1, 1'b0, 1);
        fire_b(1, 2, 1'b0, 2);
        fire_b(0, 0, 1'b1, 0);
        check("b_guess_p2", 32'(b_view_guess), 32'h0000001);
        check("b_not_done", {30'd0, b_finish, b_winner == 2'd0}, 32'd1);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
`default_nettype wire
